// File: rtl/mult_secuencial_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mult_secuencial_param
// Purpose  : WIDTH x WIDTH sequential shift-add multiplier, signed/unsigned
//            per operation, Start/Ready handshake and one-cycle Done pulse.
//            Define MULT_EARLY_TERM_EN to stop once the multiplier runs out.
// Revision : 1.0 - initial release
// ============================================================================
module mult_secuencial_param #(
   parameter int WIDTH = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Signed_mode,
   input  logic [WIDTH-1:0]     Multiplicando,
   input  logic [WIDTH-1:0]     Multiplicador,
   output logic [2*WIDTH-1:0]   Producto,
   output logic                 Ready,
   output logic                 Done
);

   localparam int C_CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_p;
   logic [2*WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]     r_q;
   logic [C_CW-1:0]      r_cnt;
   logic                 r_neg;

   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH-1:0]     w_op_a;
   logic [WIDTH-1:0]     w_op_b;
   logic                 w_neg;
   logic [WIDTH-1:0]     w_q_next;
   logic                 w_last;

   // Magnitude of the most negative operand wraps to 2^(WIDTH-1), which is
   // exactly right when the result is read back as unsigned.
   assign w_abs_a  = Multiplicando[WIDTH-1] ? (~Multiplicando + WIDTH'(1)) : Multiplicando;
   assign w_abs_b  = Multiplicador[WIDTH-1] ? (~Multiplicador + WIDTH'(1)) : Multiplicador;
   assign w_op_a   = Signed_mode ? w_abs_a : Multiplicando;
   assign w_op_b   = Signed_mode ? w_abs_b : Multiplicador;
   assign w_neg    = Signed_mode & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
   assign w_q_next = r_q >> 1;

`ifdef MULT_EARLY_TERM_EN
   assign w_last = (r_cnt == C_CW'(1)) || (w_q_next == '0);
`else
   assign w_last = (r_cnt == C_CW'(1));
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_p      <= '0;
         r_m      <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         Producto <= '0;
         Ready    <= 1'b1;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_p     <= '0;
                  r_m     <= {{WIDTH{1'b0}}, w_op_a};
                  r_q     <= w_op_b;
                  r_neg   <= w_neg;
                  r_cnt   <= C_CW'(WIDTH);
                  Ready   <= 1'b0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_q[0]) begin
                  r_p <= r_p + r_m;
               end
               r_m   <= r_m << 1;
               r_q   <= w_q_next;
               r_cnt <= r_cnt - C_CW'(1);
               if (w_last) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               Producto <= r_neg ? (~r_p + (2*WIDTH)'(1)) : r_p;
               Done     <= 1'b1;
               Ready    <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: begin
               Ready   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_secuencial_param.sv
`timescale 1ns/1ps
// Bench for mult_secuencial_param: directed WIDTH=8 vectors plus 1000 random
// WIDTH=16 operations, scoreboard-checked against an arithmetic reference.
module tb_mult_secuencial_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst8, start8, sm8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        rdy8, done8;

   logic        rst16, start16, sm16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        rdy16, done16;

   mult_secuencial_param #(.WIDTH(8)) u_dut8 (
      .Clock(clk), .Reset(rst8), .Start(start8), .Signed_mode(sm8),
      .Multiplicando(a8), .Multiplicador(b8),
      .Producto(p8), .Ready(rdy8), .Done(done8)
   );

   mult_secuencial_param #(.WIDTH(16)) u_dut16 (
      .Clock(clk), .Reset(rst16), .Start(start16), .Signed_mode(sm16),
      .Multiplicando(a16), .Multiplicador(b16),
      .Producto(p16), .Ready(rdy16), .Done(done16)
   );

   typedef struct {
      longint unsigned prod;
      int              lat;
      int              start_edge;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   exp_t e8, e16;
   longint unsigned last8 = 0;
   bit prev8 = 0, prev16 = 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer multiplication of the operands' numeric values.
   function automatic longint unsigned ref_prod(input longint unsigned a, input longint unsigned b,
                                                input bit s, input int w);
      longint sa, sb, pr;
      longint unsigned mask;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = longint'(a) - (longint'(1) << w);
      if (s && b[w-1]) sb = longint'(b) - (longint'(1) << w);
      pr   = sa * sb;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return longint'(pr) & mask;
   endfunction

   // Edges from the Start edge to the Done edge.
   function automatic int ref_lat(input longint unsigned b, input bit s, input int w);
      longint unsigned mag;
      int k;
      mag = (s && b[w-1]) ? ((64'd1 << w) - b) : b;
      k = 1;
      for (int i = 0; i < w; i++) if (mag[i]) k = i + 1;
`ifdef MULT_EARLY_TERM_EN
      return k + 1;
`else
      return w + 1;
`endif
   endfunction

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s);
      exp_t e;
      e.prod = ref_prod(a, b, s, 8);
      e.lat = ref_lat(b, s, 8);
      e.start_edge = cyc + 1;
      q8.push_back(e);
      a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input bit s);
      exp_t e;
      e.prod = ref_prod(a, b, s, 16);
      e.lat = ref_lat(b, s, 16);
      e.start_edge = cyc + 1;
      q16.push_back(e);
      a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
   endtask

   task automatic wait_done8();
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (done8) ok = 1;
      end
      chk("d8_done_seen", ok, 1);
   endtask

   task automatic wait_done16();
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (done16) ok = 1;
      end
      chk("d16_done_seen", ok, 1);
   endtask

   // Runs one WIDTH=8 operation, checking Ready low and Producto held while busy.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s, output int lat);
      int st;
      bit ok = 0;
      issue8(a, b, s);
      st = cyc;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (done8) ok = 1;
         else begin
            chk("d8_ready_low_busy", rdy8, 0);
            chk("d8_product_held", p8, last8);
         end
      end
      chk("d8_done_seen", ok, 1);
      lat = cyc - st;
   endtask

   always @(negedge clk) begin
      if (done8) begin
         chk("d8_done_width", prev8, 0);
         chk("d8_ready_with_done", rdy8, 1);
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL d8_spurious_done actual=%0h required=no_pulse", p8);
         end else begin
            e8 = q8.pop_front();
            chk("d8_product", p8, e8.prod);
            chk("d8_latency", cyc - e8.start_edge, e8.lat);
            last8 = e8.prod;
         end
      end
      prev8 = done8;
   end

   always @(negedge clk) begin
      if (done16) begin
         chk("d16_done_width", prev16, 0);
         if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL d16_spurious_done actual=%0h required=no_pulse", p16);
         end else begin
            e16 = q16.pop_front();
            chk("d16_product", p16, e16.prod);
            chk("d16_latency", cyc - e16.start_edge, e16.lat);
         end
      end
      prev16 = done16;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int exp_short;
`ifdef MULT_EARLY_TERM_EN
      exp_short = 2;
`else
      exp_short = 9;
`endif
      rst8 = 1; start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
      rst16 = 1; start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_producto", p8, 0);
      chk("reset_ready", rdy8, 1);
      chk("reset_done", done8, 0);
      rst8 = 0; rst16 = 0;
      @(posedge clk); #1;

      run8(8'hFF, 8'hFF, 0, lat);
      chk("tp_255x255", p8, 16'hFE01);
      chk("tp_255x255_latency", lat, 9);
      run8(8'hFD, 8'h05, 1, lat);
      chk("tp_m3x5", p8, 16'hFFF1);
      run8(8'h80, 8'h80, 1, lat);
      chk("tp_m128xm128", p8, 16'h4000);
      run8(8'h80, 8'h7F, 1, lat);
      chk("tp_m128x127", p8, 16'hC080);

      // Start while busy is ignored; Start in the Done cycle is accepted.
      issue8(8'h0C, 8'h0D, 0);
      repeat (2) @(posedge clk);
      #1;
      a8 = 8'hFF; b8 = 8'hFF; sm8 = 1; start8 = 1;
      @(posedge clk); #1;
      start8 = 0;
      wait_done8();
      chk("ignored_start_result", p8, 16'd156);
      issue8(8'h11, 8'hE2, 1);
      chk("b2b_ready_drops", rdy8, 0);
      wait_done8();

      // Reset sampled at the 4th BUSY edge aborts the operation silently.
      issue8(8'h37, 8'h59, 0);
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1;
      @(posedge clk); #1;
      rst8 = 0;
      q8.delete();
      last8 = 0;
      chk("abort_producto", p8, 0);
      chk("abort_ready", rdy8, 1);
      chk("abort_done", done8, 0);
      repeat (15) @(negedge clk);

      run8(8'd200, 8'd1, 0, lat);
      chk("et_200x1", p8, 16'h00C8);
      chk("et_200x1_latency", lat, exp_short);
      run8(8'd200, 8'd0, 0, lat);
      chk("et_200x0", p8, 16'h0000);
      chk("et_200x0_latency", lat, exp_short);
      run8(8'd3, 8'h80, 0, lat);
      chk("et_3x128", p8, 16'h0180);
      chk("et_3x128_latency", lat, 9);

      for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom), 1'($urandom), lat);

      for (int i = 0; i < 1000; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 16'h8000;
            1: rb = 16'h8000;
            2: rb = 16'($urandom_range(0, 3));
            default: ;
         endcase
         issue16(ra, rb, 1'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            #1;
            a16 = 16'($urandom); b16 = 16'($urandom); start16 = 1;
            @(posedge clk); #1;
            start16 = 0;
         end
         wait_done16();
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q16_drained", q16.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
